// File: rtl/hazard_pkg.sv
// Shared encodings and the per-source hazard resolution helper for the
// pipeline hazard scoreboard.
package hazard_pkg;

  // Operand source selection driven back to the EX operand muxes.
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_WB    = 2'b11
  } fwd_sel_e;

  // Age of the in-flight writer: counts down as it moves EX -> MEM -> WB.
  localparam logic [1:0] AGE_FREE = 2'd0;
  localparam logic [1:0] AGE_WB   = 2'd1;
  localparam logic [1:0] AGE_MEM  = 2'd2;
  localparam logic [1:0] AGE_EX   = 2'd3;

  typedef struct packed {
    logic     hazard;
    fwd_sel_e fwd;
  } src_res_t;

  // Decide how one source operand obtains its value given the tracked writer.
  function automatic src_res_t resolve_src(input logic used,
                                           input logic [1:0] age,
                                           input logic load,
                                           input bit fwd_en,
                                           input bit wt_rf);
    src_res_t res;
    res.hazard = 1'b0;
    res.fwd    = FWD_RF;
    if (used) begin
      if (fwd_en) begin
        case (age)
          AGE_EX: begin
            if (load) res.hazard = 1'b1;
            else      res.fwd    = FWD_EXMEM;
          end
          AGE_MEM: res.fwd = FWD_MEMWB;
          AGE_WB:  res.fwd = wt_rf ? FWD_RF : FWD_WB;
          default: res.fwd = FWD_RF;
        endcase
      end else begin
        res.hazard = (age >= AGE_MEM) || ((age == AGE_WB) && !wt_rf);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard entry: 2-bit writer age plus load flag for a register.
module sb_entry
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       set,
  input  logic       set_load,
  output logic [1:0] age,
  output logic       load
);

  // A new writer reloads the entry; otherwise the age drains towards free.
  always_ff @(posedge clk) begin
    if (rst) begin
      age  <= AGE_FREE;
      load <= 1'b0;
    end else if (set) begin
      age  <= AGE_EX;
      load <= set_load;
    end else if (age != AGE_FREE) begin
      age <= age - 2'd1;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks in-flight register writers and decides
// stall, issue, flush and operand forwarding for the instruction in ID.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG     = 16,
  parameter int AW       = $clog2(NREG),
  parameter int FWD_EN   = 1,
  parameter int WT_RF    = 1,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_rd_wen,
  input  logic            id_is_load,
  input  logic            ex_redirect,
  output logic            stall,
  output logic            issue,
  output logic            flush,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic [NREG-1:0] busy_mask,
  output logic [15:0]     stall_cnt
);

  logic [1:0] age  [NREG];
  logic       load [NREG];
  logic       set  [NREG];

  src_res_t res_a;
  src_res_t res_b;

  genvar g;
  generate
    for (g = 0; g < NREG; g++) begin : g_entry
      // R0 is hardwired when ZERO_REG is set, so its entry is never armed.
      assign set[g] = issue && id_rd_wen && (id_rd == AW'(g)) &&
                      !((ZERO_REG != 0) && (g == 0));

      sb_entry u_entry (
        .clk      (clk),
        .rst      (rst),
        .set      (set[g]),
        .set_load (id_is_load),
        .age      (age[g]),
        .load     (load[g])
      );
    end
  endgenerate

  // Hazard and forwarding decisions use the pre-update entries, so a source
  // that equals the instruction's own rd sees the older writer.
  always_comb begin
    res_a = resolve_src(id_rs1_used, age[id_rs1], load[id_rs1],
                        FWD_EN != 0, WT_RF != 0);
    res_b = resolve_src(id_rs2_used, age[id_rs2], load[id_rs2],
                        FWD_EN != 0, WT_RF != 0);
    stall = 1'b0;
    issue = 1'b0;
    flush = 1'b0;
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (!rst) begin
      flush = ex_redirect;
      stall = id_valid && !ex_redirect && (res_a.hazard || res_b.hazard);
      issue = id_valid && !ex_redirect && !stall;
      fwd_a = res_a.fwd;
      fwd_b = res_b.fwd;
    end
  end

  // Busy flags mirror any nonzero age.
  always_comb begin
    busy_mask = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      busy_mask[i] = (age[i] != AGE_FREE);
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
